// File: rtl/obstacle_pkg.sv
// obstacle_hit_scanner shared types and constants.
// Optional shadow table: OBSTACLE_SHADOW_TABLE_EN.
package obstacle_pkg;

  localparam int OBSTACLE_NUM    = 7;
  localparam int OBSTACLE_WIDTH  = 10;
  localparam int OBSTACLE_HEIGHT = 2 * OBSTACLE_WIDTH;
  localparam int BLOCK_LEN_WIDTH = 4;
  localparam int SCREEN_WIDTH    = 10;
  localparam int PHY_WIDTH       = 15;
  localparam int ID_WIDTH        = $clog2(OBSTACLE_NUM + 1);

  localparam logic [ID_WIDTH-1:0] NO_HIT = ID_WIDTH'(OBSTACLE_NUM);

  typedef logic [PHY_WIDTH-1:0]    phy_t;
  typedef logic [SCREEN_WIDTH-1:0] scr_t;
  typedef logic [ID_WIDTH-1:0]     id_t;

  typedef struct packed {
    phy_t                       pos_x;
    phy_t                       pos_y;
    logic [BLOCK_LEN_WIDTH-1:0] len;
  } obstacle_entry_t;

endpackage

// File: rtl/obstacle_hit_unit.sv
// Per-entry hit test: horizontal span in blocks, vertical
// extent with wrap-around in the absolute y space.
module obstacle_hit_unit
  import obstacle_pkg::*;
(
  input  obstacle_entry_t entry,
  input  phy_t            abs_x,
  input  phy_t            abs_y,
  output logic            hit,
  output phy_t            dx,
  output phy_t            dy
);

  phy_t span;

  assign dx   = abs_x - entry.pos_x;
  assign dy   = abs_y - entry.pos_y;
  assign span = PHY_WIDTH'(entry.len)
              * PHY_WIDTH'(OBSTACLE_WIDTH);

  assign hit = (entry.len != '0)
            && (abs_x >= entry.pos_x)
            && (dx < span)
            && (dy < PHY_WIDTH'(OBSTACLE_HEIGHT));

endmodule

// File: rtl/obstacle_hit_scanner.sv
// Pixel-to-obstacle locator, 2-cycle pipeline.
// Optional shadow table: OBSTACLE_SHADOW_TABLE_EN.
module obstacle_hit_scanner
  import obstacle_pkg::*;
(
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       pixel_valid,
  input  logic [SCREEN_WIDTH-1:0]    pixel_x,
  input  logic [SCREEN_WIDTH-1:0]    pixel_y,
  input  logic [PHY_WIDTH-1:0]       camera_y,
  input  logic                       frame_start,
  input  logic                       wr_en,
  input  logic [ID_WIDTH-1:0]        wr_id,
  input  logic [PHY_WIDTH-1:0]       wr_pos_x,
  input  logic [PHY_WIDTH-1:0]       wr_pos_y,
  input  logic [BLOCK_LEN_WIDTH-1:0] wr_len,
  output logic                       out_valid,
  output logic                       obstacle_on,
  output logic [ID_WIDTH-1:0]        obstacle_on_id,
  output logic [SCREEN_WIDTH-1:0]    obstacle_x_rom,
  output logic [SCREEN_WIDTH-1:0]    obstacle_y_rom,
  output logic [PHY_WIDTH-1:0]       obstacle_abs_pos_x,
  output logic [PHY_WIDTH-1:0]       obstacle_abs_pos_y
);

  obstacle_entry_t tbl [OBSTACLE_NUM];
  obstacle_entry_t wr_entry;
  logic            wr_ok;

  assign wr_ok    = wr_en
                 && (wr_id < ID_WIDTH'(OBSTACLE_NUM));
  assign wr_entry = '{pos_x: wr_pos_x,
                      pos_y: wr_pos_y,
                      len:   wr_len};

`ifdef OBSTACLE_SHADOW_TABLE_EN
  obstacle_entry_t shd [OBSTACLE_NUM];

  // Copy takes the pre-edge shadow, so a coincident write waits a frame
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < OBSTACLE_NUM; i++) begin
        tbl[i] <= '0;
        shd[i] <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int i = 0; i < OBSTACLE_NUM; i++)
          tbl[i] <= shd[i];
      end
      if (wr_ok)
        shd[wr_id] <= wr_entry;
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < OBSTACLE_NUM; i++)
        tbl[i] <= '0;
    end else if (wr_ok) begin
      tbl[wr_id] <= wr_entry;
    end
  end
`endif

  phy_t                    abs_x;
  phy_t                    abs_y;
  logic [OBSTACLE_NUM-1:0] hit_c;
  phy_t                    dx_c [OBSTACLE_NUM];
  phy_t                    dy_c [OBSTACLE_NUM];

  assign abs_x = {{(PHY_WIDTH-SCREEN_WIDTH){1'b0}}, pixel_x};
  assign abs_y = camera_y + PHY_WIDTH'(pixel_y);

  for (genvar g = 0; g < OBSTACLE_NUM; g++) begin : g_hit
    obstacle_hit_unit u_hit (
      .entry (tbl[g]),
      .abs_x (abs_x),
      .abs_y (abs_y),
      .hit   (hit_c[g]),
      .dx    (dx_c[g]),
      .dy    (dy_c[g])
    );
  end

  logic                    v1;
  logic [OBSTACLE_NUM-1:0] hit1;
  phy_t                    dx1 [OBSTACLE_NUM];
  phy_t                    dy1 [OBSTACLE_NUM];
  phy_t                    ax1;
  phy_t                    ay1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1   <= 1'b0;
      hit1 <= '0;
      ax1  <= '0;
      ay1  <= '0;
      for (int i = 0; i < OBSTACLE_NUM; i++) begin
        dx1[i] <= '0;
        dy1[i] <= '0;
      end
    end else begin
      v1 <= pixel_valid;
      if (pixel_valid) begin
        hit1 <= hit_c;
        ax1  <= abs_x;
        ay1  <= abs_y;
        for (int i = 0; i < OBSTACLE_NUM; i++) begin
          dx1[i] <= dx_c[i];
          dy1[i] <= dy_c[i];
        end
      end
    end
  end

  logic sel_on;
  id_t  sel_id;
  phy_t dx_sel;
  phy_t dy_sel;
  phy_t blk;
  phy_t x_off;
  phy_t pos_x_c;
  phy_t pos_y_c;

  // Descending scan so the lowest hitting id is the last to assign
  always_comb begin
    sel_on = 1'b0;
    sel_id = NO_HIT;
    dx_sel = '0;
    dy_sel = '0;
    for (int i = OBSTACLE_NUM - 1; i >= 0; i--) begin
      if (hit1[i]) begin
        sel_on = 1'b1;
        sel_id = ID_WIDTH'(i);
        dx_sel = dx1[i];
        dy_sel = dy1[i];
      end
    end
  end

  assign blk     = dx_sel / PHY_WIDTH'(OBSTACLE_WIDTH);
  assign x_off   = dx_sel - blk * PHY_WIDTH'(OBSTACLE_WIDTH);
  assign pos_x_c = sel_on ? (ax1 - x_off) : '0;
  assign pos_y_c = sel_on ? (ay1 - dy_sel) : '0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_valid          <= 1'b0;
      obstacle_on        <= 1'b0;
      obstacle_on_id     <= NO_HIT;
      obstacle_x_rom     <= '0;
      obstacle_y_rom     <= '0;
      obstacle_abs_pos_x <= '0;
      obstacle_abs_pos_y <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        obstacle_on        <= sel_on;
        obstacle_on_id     <= sel_id;
        obstacle_x_rom     <= SCREEN_WIDTH'(x_off);
        obstacle_y_rom     <= SCREEN_WIDTH'(dy_sel);
        obstacle_abs_pos_x <= pos_x_c;
        obstacle_abs_pos_y <= pos_y_c;
      end
    end
  end

endmodule

// File: tb/tb_obstacle_hit_scanner.sv
// Bench for obstacle_hit_scanner: directed steps plus
// targeted random pixels against a table-level model.
module tb_obstacle_hit_scanner;
  import obstacle_pkg::*;

  logic                       sys_clk = 1'b0;
  logic                       sys_rst_n = 1'b1;
  logic                       pixel_valid = 1'b0;
  logic [SCREEN_WIDTH-1:0]    pixel_x = '0;
  logic [SCREEN_WIDTH-1:0]    pixel_y = '0;
  logic [PHY_WIDTH-1:0]       camera_y = '0;
  logic                       frame_start = 1'b0;
  logic                       wr_en = 1'b0;
  logic [ID_WIDTH-1:0]        wr_id = '0;
  logic [PHY_WIDTH-1:0]       wr_pos_x = '0;
  logic [PHY_WIDTH-1:0]       wr_pos_y = '0;
  logic [BLOCK_LEN_WIDTH-1:0] wr_len = '0;
  logic                       out_valid;
  logic                       obstacle_on;
  logic [ID_WIDTH-1:0]        obstacle_on_id;
  logic [SCREEN_WIDTH-1:0]    obstacle_x_rom;
  logic [SCREEN_WIDTH-1:0]    obstacle_y_rom;
  logic [PHY_WIDTH-1:0]       obstacle_abs_pos_x;
  logic [PHY_WIDTH-1:0]       obstacle_abs_pos_y;

  obstacle_hit_scanner dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .pixel_valid        (pixel_valid),
    .pixel_x            (pixel_x),
    .pixel_y            (pixel_y),
    .camera_y           (camera_y),
    .frame_start        (frame_start),
    .wr_en              (wr_en),
    .wr_id              (wr_id),
    .wr_pos_x           (wr_pos_x),
    .wr_pos_y           (wr_pos_y),
    .wr_len             (wr_len),
    .out_valid          (out_valid),
    .obstacle_on        (obstacle_on),
    .obstacle_on_id     (obstacle_on_id),
    .obstacle_x_rom     (obstacle_x_rom),
    .obstacle_y_rom     (obstacle_y_rom),
    .obstacle_abs_pos_x (obstacle_abs_pos_x),
    .obstacle_abs_pos_y (obstacle_abs_pos_y)
  );

  always #5 sys_clk = ~sys_clk;

  localparam int YMOD = 1 << PHY_WIDTH;

  typedef struct {
    bit on;
    int id;
    int xr;
    int yr;
    int ax;
    int ay;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   a_px [OBSTACLE_NUM];
  int   a_py [OBSTACLE_NUM];
  int   a_ln [OBSTACLE_NUM];
  int   s_px [OBSTACLE_NUM];
  int   s_py [OBSTACLE_NUM];
  int   s_ln [OBSTACLE_NUM];
  bit   s1_v;
  bit   out_v;
  exp_t s1_e;
  exp_t out_e;

  function automatic exp_t no_hit();
    exp_t e;
    e = '{0, OBSTACLE_NUM, 0, 0, 0, 0};
    return e;
  endfunction

  function automatic exp_t ref_model(int px, int py, int cam);
    exp_t e;
    int   ay, dx, dy;
    e  = no_hit();
    ay = (cam + py) % YMOD;
    for (int i = 0; i < OBSTACLE_NUM; i++) begin
      dx = px - a_px[i];
      dy = (ay - a_py[i] + YMOD) % YMOD;
      if (!e.on && a_ln[i] != 0 && dx >= 0
          && dx < a_ln[i] * OBSTACLE_WIDTH
          && dy < 2 * OBSTACLE_WIDTH) begin
        e.on = 1;
        e.id = i;
        e.xr = dx % OBSTACLE_WIDTH;
        e.yr = dy;
        e.ax = a_px[i] + (dx / OBSTACLE_WIDTH) * OBSTACLE_WIDTH;
        e.ay = a_py[i];
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < OBSTACLE_NUM; i++) begin
      a_px[i] = 0; a_py[i] = 0; a_ln[i] = 0;
      s_px[i] = 0; s_py[i] = 0; s_ln[i] = 0;
    end
    s1_v  = 0;
    out_v = 0;
    out_e = no_hit();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: got %0d expected %0d",
             tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(out_v));
    chk("on", 32'(obstacle_on), 32'(out_e.on));
    chk("id", 32'(obstacle_on_id), out_e.id);
    chk("x_rom", 32'(obstacle_x_rom), out_e.xr);
    chk("y_rom", 32'(obstacle_y_rom), out_e.yr);
    chk("abs_x", 32'(obstacle_abs_pos_x), out_e.ax);
    chk("abs_y", 32'(obstacle_abs_pos_y), out_e.ay);
  endtask

  task automatic cyc(input bit v, input int px, input int py,
                     input int cam, input bit we, input int wid,
                     input int wx, input int wy, input int wl,
                     input bit fs);
    px  = px & 1023;
    py  = py & 1023;
    cam = cam & (YMOD - 1);
    pixel_valid = v;
    pixel_x     = SCREEN_WIDTH'(px);
    pixel_y     = SCREEN_WIDTH'(py);
    camera_y    = PHY_WIDTH'(cam);
    wr_en       = we;
    wr_id       = ID_WIDTH'(wid);
    wr_pos_x    = PHY_WIDTH'(wx);
    wr_pos_y    = PHY_WIDTH'(wy);
    wr_len      = BLOCK_LEN_WIDTH'(wl);
    frame_start = fs;
    @(posedge sys_clk);
    if (s1_v) out_e = s1_e;
    out_v = s1_v;
    s1_v  = v;
    if (v) s1_e = ref_model(px, py, cam);
`ifdef OBSTACLE_SHADOW_TABLE_EN
    if (fs) begin
      a_px = s_px; a_py = s_py; a_ln = s_ln;
    end
    if (we && wid < OBSTACLE_NUM) begin
      s_px[wid] = wx; s_py[wid] = wy; s_ln[wid] = wl;
    end
`else
    if (we && wid < OBSTACLE_NUM) begin
      a_px[wid] = wx; a_py[wid] = wy; a_ln[wid] = wl;
    end
`endif
    #1;
    check_all();
  endtask

  task automatic pix(input bit v, input int px,
                     input int py, input int cam);
    cyc(v, px, py, cam, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int id, input int x,
                    input int y, input int l);
    cyc(0, 0, 0, 0, 1, id, x, y, l, 0);
  endtask

  task automatic fstart();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic drain();
    pix(0, 0, 0, 0);
    pix(0, 0, 0, 0);
  endtask

  int k, px, py, cam, ay;

  initial begin
    model_reset();
    #2 sys_rst_n = 1'b0;
    #1 check_all();
    @(posedge sys_clk);
    #1 check_all();
    sys_rst_n = 1'b1;

    // basic hit and the two near-miss boundaries
    wr(2, 100, 200, 3);
    pix(1, 125, 60, 150);
    drain();
    pix(1, 130, 60, 150);
    pix(1, 125, 70, 150);
    drain();

    // priority, then disabling the winner in the same cycle
    wr(1, 45, 45, 1);
    wr(4, 40, 40, 2);
    cyc(1, 50, 50, 0, 1, 1, 0, 0, 0, 0);
    pix(1, 50, 50, 0);
    drain();

    // ignored out-of-range id, vertical wrap, no horizontal wrap
    wr(7, 0, 0, 15);
    wr(0, 0, 32765, 1);
    pix(1, 3, 10, 32760);
    pix(1, 1020, 10, 32760);
    drain();

    // bubbles and then reset mid-stream
    pix(1, 125, 60, 150);
    pix(1, 50, 50, 0);
    pix(0, 0, 0, 0);
    pix(1, 3, 10, 32760);
    pix(1, 125, 60, 150);
    pix(1, 50, 50, 0);
    sys_rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge sys_clk);
    #1 check_all();
    sys_rst_n = 1'b1;
    pix(1, 125, 60, 150);
    pix(1, 125, 60, 150);
    drain();

    // frame_start gating (table write is immediate without shadow)
    wr(3, 300, 500, 2);
    pix(1, 305, 5, 500);
    fstart();
    pix(1, 305, 5, 500);
    cyc(0, 0, 0, 0, 1, 5, 600, 100, 1, 1);
    pix(1, 601, 1, 100);
    fstart();
    pix(1, 601, 1, 100);
    drain();

    // targeted random traffic
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, OBSTACLE_NUM - 1);
      if ($urandom_range(0, 4) == 0) begin
        cyc($urandom_range(0, 1) == 1,
            $urandom, $urandom, $urandom,
            1, $urandom_range(0, 7), $urandom_range(0, 999),
            $urandom_range(0, YMOD - 1), $urandom_range(0, 15),
            $urandom_range(0, 9) == 0);
      end else begin
        px  = a_px[k] + $urandom_range(0, a_ln[k] * 10 + 5);
        ay  = a_py[k] + $urandom_range(0, 23) - 2;
        py  = $urandom_range(0, 1023);
        cam = (ay - py + 2 * YMOD) % YMOD;
        cyc($urandom_range(0, 4) != 0, px, py, cam,
            0, 0, 0, 0, 0, $urandom_range(0, 19) == 0);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_hit_scanner.md
# obstacle_hit_scanner

Pixel-to-obstacle locator feeding the obstacle display controller. Holds a small obstacle table (position and length in blocks per obstacle), compares each incoming VGA pixel against every entry in parallel after applying the vertical camera offset, and emits the winning obstacle id, in-block ROM coordinates and the block's absolute position through a fixed-latency pipeline. Sits between the VGA timing generator / camera logic and the display controller's `obstacle_on`, `obstacle_on_id`, `obstacle_x_rom`, `obstacle_y_rom` and `obstacle_abs_pos_*` inputs.

## Interface
- OBSTACLE_NUM, 7, table entries; ids 0..OBSTACLE_NUM-1
- OBSTACLE_WIDTH, 10, block width in pixels; block height is 2*OBSTACLE_WIDTH
- BLOCK_LEN_WIDTH, 4, width of per-obstacle length in blocks (max 15)
- SCREEN_WIDTH, 10, pixel coordinate and ROM coordinate width
- PHY_WIDTH, 15, absolute world coordinate width
- ID_WIDTH, $clog2(OBSTACLE_NUM+1), id width (local, derived)
- sys_clk  in  1  single clock
- sys_rst_n  in  1  asynchronous active-low reset
- pixel_valid  in  1  pixel_x/pixel_y/camera_y valid this cycle
- pixel_x, pixel_y  in  SCREEN_WIDTH  screen pixel coordinate
- camera_y  in  PHY_WIDTH  absolute y of screen row 0
- frame_start  in  1  one-cycle pulse at frame start
- wr_en  in  1  table write strobe
- wr_id  in  ID_WIDTH  entry to write; values ≥ OBSTACLE_NUM ignored
- wr_pos_x, wr_pos_y  in  PHY_WIDTH  obstacle top-left absolute position
- wr_len  in  BLOCK_LEN_WIDTH  length in blocks; 0 disables entry
- out_valid  out  1  outputs below valid
- obstacle_on  out  1  pixel covered by an enabled obstacle
- obstacle_on_id  out  ID_WIDTH  winning id; OBSTACLE_NUM when no hit
- obstacle_x_rom, obstacle_y_rom  out  SCREEN_WIDTH  in-block coordinate
- obstacle_abs_pos_x, obstacle_abs_pos_y  out  PHY_WIDTH  absolute top-left of the hit block

## Operation
- abs_y = (camera_y + pixel_y) mod 2^PHY_WIDTH; abs_x = pixel_x zero-extended (no horizontal scroll).
- Per entry i: dx = abs_x - pos_x, dy = (abs_y - pos_y) mod 2^PHY_WIDTH, both unsigned PHY_WIDTH. Hit iff len≠0, abs_x ≥ pos_x, dx < len*OBSTACLE_WIDTH, dy < 2*OBSTACLE_WIDTH. Vertical wrap-around is a hit; horizontal is not.
- Multiple hits: lowest id wins.
- Hit outputs: blk = dx / OBSTACLE_WIDTH; obstacle_x_rom = dx mod OBSTACLE_WIDTH; obstacle_y_rom = dy (0..2W-1); obstacle_abs_pos_x = pos_x + blk*OBSTACLE_WIDTH; obstacle_abs_pos_y = pos_y.
- No hit: obstacle_on=0, id=OBSTACLE_NUM, ROM and abs outputs 0.
- Division by constant only; no generic divider.
- Table write: entry wr_id takes {wr_pos_x, wr_pos_y, wr_len} at the clock edge.

## Timing
- Latency exactly 2 cycles: pixel sampled at edge N (pixel_valid=1) → outputs and out_valid=1 after edge N+2. Stage 1 registers abs_y, per-entry hit, dx and dy. Stage 2 registers priority select and block divide.
- Throughput 1 pixel/cycle. Bubbles (pixel_valid=0) propagate as out_valid=0. Outputs hold their last value while out_valid=0.
- Reset: all outputs 0 except obstacle_on_id = OBSTACLE_NUM. All entries len=0. Pipeline valid bits cleared.
- Reset asserted mid-stream: in-flight pixels dropped; no out_valid until 2 cycles after the first post-reset pixel_valid.
- Without the macro, a write at edge N is used by pixels sampled at edge N+1 onward.

## Configuration
- OBSTACLE_SHADOW_TABLE_EN defined: writes go to a shadow table. On frame_start, shadow is copied to active in one cycle. A write in the same cycle as frame_start lands in shadow and is excluded from that copy. Pixels use active only. Reset clears both tables.
- Not defined: a single table, written directly; frame_start is ignored.

## Structure
- Shared package obstacle_pkg: OBSTACLE_HEIGHT = 2*OBSTACLE_WIDTH, NO_HIT id constant, packed entry typedef {pos_x, pos_y, len}.
- Sub-module obstacle_hit_unit: one per entry via generate. Computes hit, dx and dy for one entry (stage 1 combinational).

## Test plan
- Write id2 with pos (100,200), len 3; camera_y=150, pixel (125,60) → 2 cycles later: on=1, id=2, x_rom=5, y_rom=10, abs_pos=(120,200).
- Same table; pixel_x=130 (dx=30) and pixel_y=70 (dy=20) → on=0, id=7, all ROM/abs outputs 0.
- id1 and id4 both covering pixel (50,50) → id=1. Then write id1 len=0 → same pixel gives id=4 from the next pixel onward.
- Vertical wrap: id0 pos_y=32765, pos_x=0, len=1; camera_y=32760, pixel (3,10) → abs_y=2, on=1, y_rom=5, x_rom=3.
- Streaming: pixel_valid pattern 1,1,0,1 → out_valid 1,1,0,1 delayed by exactly 2 cycles. Assert sys_rst_n low mid-stream → outputs return to reset values immediately, no stale out_valid.
- With OBSTACLE_SHADOW_TABLE_EN: write id3 → no hit until after frame_start. A write coincident with frame_start appears only after the following frame_start.
